// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-specifier width and the NOP word loaded by a flushed IF/ID register.
package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_STALL  = 2'd1,
    MEM_WAIT    = 2'd2,
    ERR_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds the instruction
// sitting in IF/ID. Register 0 is hard-wired and never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest_reg,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use
);

  assign load_use = ex_mem_read && (ex_dest_reg != '0) &&
                    ((ex_dest_reg == id_rs) || (ex_dest_reg == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory
// wait states with timeout. Optional stall counter under PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W       = pipe_pkg::REG_W,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest_reg,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_nxt;
  logic              load_use;
  logic              frozen, lu_stall, br_flush;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_dest_reg (ex_dest_reg),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .load_use    (load_use)
  );

  // Event priority: memory wait, then load-use, then branch flush.
  // The cycle a memory wait releases behaves like RUN so a held branch is acted on.
  always_comb begin
    frozen   = 1'b0;
    lu_stall = 1'b0;
    br_flush = 1'b0;
    case (state)
      RUN: begin
        frozen   = mem_req && !mem_ready;
        lu_stall = !frozen && load_use;
        br_flush = !frozen && !lu_stall && branch_taken;
      end
      LOAD_STALL: begin
        frozen   = mem_req && !mem_ready;
        br_flush = !frozen && branch_taken;
      end
      MEM_WAIT: begin
        frozen   = !mem_ready;
        lu_stall = !frozen && load_use;
        br_flush = !frozen && !lu_stall && branch_taken;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_en      = 1'b0;
      idex_bubble  = 1'b1;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else begin
      pc_en        = !(frozen || lu_stall);
      ifid_en      = !(frozen || lu_stall);
      ifid_flush   = br_flush;
      idex_en      = !frozen;
      idex_bubble  = lu_stall || br_flush;
      exmem_en     = !frozen;
      memwb_bubble = frozen || (state == ERR_RELEASE);
    end
  end

  always_comb begin
    state_nxt = RUN;
    wait_nxt  = '0;
    err_nxt   = mem_err;
    if (frozen) begin
      if (state != MEM_WAIT) begin
        state_nxt = MEM_WAIT;
        wait_nxt  = WAIT_W'(1);
      end else if (wait_cnt == WAIT_LAST) begin
        state_nxt = ERR_RELEASE;
        err_nxt   = 1'b1;
      end else begin
        state_nxt = MEM_WAIT;
        wait_nxt  = wait_cnt + WAIT_W'(1);
      end
    end else if (lu_stall) begin
      state_nxt = LOAD_STALL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (!pc_en && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
